// File: rtl/binary_game_pkg.sv
// Shared types and constants for the binary guessing game: FSM states,
// the 8-bit value width, and the LFSR feedback taps.
package binary_game_pkg;

  localparam int VAL_W = 8;

  // Taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7,5,4,3 of a left-shifting register)
  localparam logic [VAL_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GUARD,
    S_PLAY,
    S_RESULT,
    S_OVER
  } state_t;

  function automatic logic [VAL_W-1:0] lfsr_step(input logic [VAL_W-1:0] v);
    return {v[VAL_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; a nonzero seed keeps it out of the
// all-zero lock-up state forever.
module lfsr8
  import binary_game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] seed,
  output logic [VAL_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= seed;
    else     q <= lfsr_step(q);
  end

endmodule

// File: rtl/round_ctrl.sv
// Round/game controller for the binary guessing game.
// Optional build macro HOLD_CONFIRM_EN: a match must persist CONFIRM_CYCLES cycles.
module round_ctrl
  import binary_game_pkg::*;
#(
  parameter int             ROUND_TICKS    = 10,
  parameter int             MAX_ROUNDS     = 8,
  parameter logic [VAL_W-1:0] LFSR_SEED    = 8'hA5,
  parameter int             CONFIRM_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             tick,
  input  logic             is_equal,
  output logic [VAL_W-1:0] number,
  output logic [VAL_W-1:0] score,
  output logic [VAL_W-1:0] time_left,
  output logic [VAL_W-1:0] round_idx,
  output logic             playing,
  output logic             game_over,
  output logic             hit,
  output logic             miss
);

  localparam logic [VAL_W-1:0] TICKS_LOAD = VAL_W'(ROUND_TICKS);
  localparam logic [VAL_W:0]   ROUNDS_END = (VAL_W+1)'(MAX_ROUNDS);

  if (ROUND_TICKS < 1 || ROUND_TICKS > 255 || MAX_ROUNDS < 1 || MAX_ROUNDS > 255 ||
      CONFIRM_CYCLES < 1 || CONFIRM_CYCLES > 255 || LFSR_SEED == '0) begin : g_bad_cfg
    $error("round_ctrl: parameter out of range");
  end

  function automatic logic [VAL_W-1:0] sat_inc(input logic [VAL_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t           state, state_next;
  logic [VAL_W-1:0] lfsr_q;
  logic             guard_cnt;
  logic             match;
  logic             load, clear_game, dec, set_hit, set_miss, inc_round;
  logic             last_round;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

`ifdef HOLD_CONFIRM_EN
  localparam logic [VAL_W-1:0] HOLD_LAST = VAL_W'(CONFIRM_CYCLES - 1);
  logic [VAL_W-1:0] hold_cnt;

  assign match = is_equal && (hold_cnt == HOLD_LAST);

  // Counts consecutive matching PLAY cycles; any gap or leaving PLAY restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hold_cnt <= '0;
    else if (state == S_PLAY && state_next == S_PLAY && is_equal)
      hold_cnt <= hold_cnt + 1'b1;
    else
      hold_cnt <= '0;
  end
`else
  assign match = is_equal;
`endif

  assign last_round = ({1'b0, round_idx} + 1'b1) == ROUNDS_END;
  assign playing    = (state == S_GUARD) || (state == S_PLAY);
  assign game_over  = (state == S_OVER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    clear_game = 1'b0;
    dec        = 1'b0;
    set_hit    = 1'b0;
    set_miss   = 1'b0;
    inc_round  = 1'b0;
    case (state)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_next = S_LOAD;
          clear_game = 1'b1;
        end
      end
      S_LOAD: begin
        load       = 1'b1;
        state_next = S_GUARD;
      end
      S_GUARD: begin
        if (guard_cnt) state_next = S_PLAY;
      end
      S_PLAY: begin
        dec = tick && (time_left != '0);
        if (match) begin
          set_hit    = 1'b1;
          state_next = S_RESULT;
        end else if (tick && time_left == VAL_W'(1)) begin
          set_miss   = 1'b1;
          state_next = S_RESULT;
        end
      end
      S_RESULT: begin
        inc_round  = 1'b1;
        state_next = last_round ? S_OVER : S_LOAD;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers; reset clears everything so an abandoned round leaves no pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      number    <= '0;
      score     <= '0;
      time_left <= '0;
      round_idx <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      guard_cnt <= 1'b0;
    end else begin
      hit       <= set_hit;
      miss      <= set_miss;
      guard_cnt <= (state == S_GUARD) && !guard_cnt;
      if (load) begin
        number    <= lfsr_q;
        time_left <= TICKS_LOAD;
      end else if (dec) begin
        time_left <= time_left - 1'b1;
      end
      if (clear_game)   score <= '0;
      else if (set_hit) score <= sat_inc(score);
      if (clear_game)     round_idx <= '0;
      else if (inc_round) round_idx <= sat_inc(round_idx);
    end
  end

endmodule

// File: tb/tb_round_ctrl.sv
// Directed, table-driven bench for round_ctrl (ROUND_TICKS=3, MAX_ROUNDS=2).
module tb_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, tick, is_equal;
  logic [7:0] number, score, time_left, round_idx;
  logic       playing, game_over, hit, miss;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       st, tk, eq;
    logic       pl, go, ht, ms;
    logic [7:0] tl, sc, ri;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  round_ctrl #(
    .ROUND_TICKS    (3),
    .MAX_ROUNDS     (2),
    .LFSR_SEED      (8'hA5),
    .CONFIRM_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tick      (tick),
    .is_equal  (is_equal),
    .number    (number),
    .score     (score),
    .time_left (time_left),
    .round_idx (round_idx),
    .playing   (playing),
    .game_over (game_over),
    .hit       (hit),
    .miss      (miss)
  );

  function automatic vec_t mk(input logic st, tk, eq, pl, go, ht, ms,
                              input logic [7:0] tl, sc, ri);
    vec_t v;
    v.st = st; v.tk = tk; v.eq = eq;
    v.pl = pl; v.go = go; v.ht = ht; v.ms = ms;
    v.tl = tl; v.sc = sc; v.ri = ri;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " number"},    number,          8'h00);
    chk({tag, " score"},     score,           8'h00);
    chk({tag, " time_left"}, time_left,       8'h00);
    chk({tag, " round_idx"}, round_idx,       8'h00);
    chk({tag, " playing"},   8'(playing),     8'h00);
    chk({tag, " game_over"}, 8'(game_over),   8'h00);
    chk({tag, " hit"},       8'(hit),         8'h00);
    chk({tag, " miss"},      8'(miss),        8'h00);
  endtask

  initial begin
`ifdef HOLD_CONFIRM_EN
    // st tk eq | pl go ht ms | tl sc ri   (expected after the edge consuming the row)
    tbl.push_back(mk(1,0,1, 0,0,0,0, 0,0,0));  // IDLE -> LOAD
    tbl.push_back(mk(0,0,1, 1,0,0,0, 3,0,0));  // GUARD 1
    tbl.push_back(mk(0,0,1, 1,0,0,0, 3,0,0));  // GUARD 2
    tbl.push_back(mk(0,0,1, 1,0,0,0, 3,0,0));  // PLAY
    tbl.push_back(mk(0,0,1, 1,0,0,0, 3,0,0));  // hold 1
    tbl.push_back(mk(0,0,1, 1,0,0,0, 3,0,0));  // hold 2
    tbl.push_back(mk(0,0,1, 1,0,0,0, 3,0,0));  // hold 3
    tbl.push_back(mk(0,0,1, 0,0,1,0, 3,1,0));  // 4th PLAY cycle -> hit
    tbl.push_back(mk(0,0,0, 0,0,0,0, 3,1,1));  // RESULT -> LOAD
    tbl.push_back(mk(0,0,0, 1,0,0,0, 3,1,1));
    tbl.push_back(mk(0,0,0, 1,0,0,0, 3,1,1));
    tbl.push_back(mk(0,0,0, 1,0,0,0, 3,1,1));  // PLAY
    tbl.push_back(mk(0,0,1, 1,0,0,0, 3,1,1));  // pattern 1,1,1,0,1,1,1,1
    tbl.push_back(mk(0,0,1, 1,0,0,0, 3,1,1));
    tbl.push_back(mk(0,0,1, 1,0,0,0, 3,1,1));
    tbl.push_back(mk(0,0,0, 1,0,0,0, 3,1,1));
    tbl.push_back(mk(0,0,1, 1,0,0,0, 3,1,1));
    tbl.push_back(mk(0,0,1, 1,0,0,0, 3,1,1));
    tbl.push_back(mk(0,0,1, 1,0,0,0, 3,1,1));
    tbl.push_back(mk(0,0,1, 0,0,1,0, 3,2,1));  // hit after 8th cycle
    tbl.push_back(mk(0,0,0, 0,1,0,0, 3,2,2));  // OVER
`else
    tbl.push_back(mk(1,0,1, 0,0,0,0, 0,0,0));  // IDLE -> LOAD
    tbl.push_back(mk(0,0,1, 1,0,0,0, 3,0,0));  // GUARD 1, match masked
    tbl.push_back(mk(0,0,1, 1,0,0,0, 3,0,0));  // GUARD 2
    tbl.push_back(mk(0,0,1, 1,0,0,0, 3,0,0));  // PLAY
    tbl.push_back(mk(0,0,1, 0,0,1,0, 3,1,0));  // 1st PLAY cycle -> hit
    tbl.push_back(mk(0,0,0, 0,0,0,0, 3,1,1));  // RESULT -> LOAD
    tbl.push_back(mk(0,0,0, 1,0,0,0, 3,1,1));
    tbl.push_back(mk(0,1,0, 1,0,0,0, 3,1,1));  // tick ignored in GUARD
    tbl.push_back(mk(0,1,1, 1,0,0,0, 3,1,1));  // tick/match ignored in GUARD
    tbl.push_back(mk(0,1,0, 1,0,0,0, 2,1,1));
    tbl.push_back(mk(1,0,0, 1,0,0,0, 2,1,1));  // start ignored in PLAY
    tbl.push_back(mk(0,1,0, 1,0,0,0, 1,1,1));
    tbl.push_back(mk(0,1,0, 0,0,0,1, 0,1,1));  // final tick -> miss
    tbl.push_back(mk(1,0,0, 0,1,0,0, 0,1,2));  // RESULT -> OVER, start ignored
    tbl.push_back(mk(0,1,1, 0,1,0,0, 0,1,2));  // OVER holds
    tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0));  // restart clears score/round
    tbl.push_back(mk(0,0,0, 1,0,0,0, 3,0,0));
    tbl.push_back(mk(0,0,0, 1,0,0,0, 3,0,0));
    tbl.push_back(mk(0,0,0, 1,0,0,0, 3,0,0));  // PLAY
    tbl.push_back(mk(0,1,0, 1,0,0,0, 2,0,0));
    tbl.push_back(mk(0,1,0, 1,0,0,0, 1,0,0));
    tbl.push_back(mk(0,1,1, 0,0,1,0, 0,1,0));  // final tick + match -> hit wins
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0,1,1));
    tbl.push_back(mk(0,0,0, 1,0,0,0, 3,1,1));
    tbl.push_back(mk(0,0,0, 1,0,0,0, 3,1,1));
    tbl.push_back(mk(0,0,0, 1,0,0,0, 3,1,1));  // PLAY
    tbl.push_back(mk(0,0,1, 0,0,1,0, 3,2,1));  // second win
    tbl.push_back(mk(0,0,0, 0,1,0,0, 3,2,2));  // OVER after 2 rounds
    tbl.push_back(mk(1,0,0, 0,0,0,0, 3,0,0));  // new game
    tbl.push_back(mk(0,0,0, 1,0,0,0, 3,0,0));
`endif

    rst = 1'b1; start = 1'b0; tick = 1'b0; is_equal = 1'b0;
    #1 chk_reset("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st; tick = tbl[i].tk; is_equal = tbl[i].eq;
      @(negedge clk);
      chk($sformatf("row%0d playing", i),   8'(playing),   8'(tbl[i].pl));
      chk($sformatf("row%0d game_over", i), 8'(game_over), 8'(tbl[i].go));
      chk($sformatf("row%0d hit", i),       8'(hit),       8'(tbl[i].ht));
      chk($sformatf("row%0d miss", i),      8'(miss),      8'(tbl[i].ms));
      chk($sformatf("row%0d time_left", i), time_left,     tbl[i].tl);
      chk($sformatf("row%0d score", i),     score,         tbl[i].sc);
      chk($sformatf("row%0d round_idx", i), round_idx,     tbl[i].ri);
    end

    // Asynchronous reset, then LFSR restart: first LOAD captures step(A5) = 4A.
    start = 1'b0; tick = 1'b0; is_equal = 1'b0;
    rst = 1'b1;
    #1 chk_reset("rst_async");
    @(negedge clk);
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("load number", number, 8'h4A);
    chk("load time_left", time_left, 8'd3);
    @(negedge clk);
    @(negedge clk);
    chk("number held", number, 8'h4A);
    chk("in play", 8'(playing), 8'h01);

    // Reset in the middle of PLAY with a match pending: no pulse may escape.
    is_equal = 1'b1;
    rst = 1'b1;
    #1 chk_reset("rst_midplay");
    @(negedge clk);
    chk_reset("rst_held");
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("post-rst hit", 8'(hit), 8'h00);
    @(negedge clk);
    chk("restart number", number, 8'h4A);
    chk("restart hit", 8'(hit), 8'h00);
    chk("restart miss", 8'(miss), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 SHALL have parameter ROUND_TICKS, default 10, meaning ticks allowed per round (1..255).
REQ-002 SHALL have parameter MAX_ROUNDS, default 8, meaning rounds per game (1..255).
REQ-003 SHALL have parameter LFSR_SEED, default 8'hA5, meaning nonzero LFSR reset value.
REQ-004 SHALL have parameter CONFIRM_CYCLES, default 4, meaning hold length for confirmed match (used only under HOLD_CONFIRM_EN).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse; begins or restarts a game.
REQ-008 tick  input  1  one-cycle timebase enable, e.g. 1 Hz.
REQ-009 is_equal  input  1  registered switch-equals-number flag from the comparator stage.
REQ-010 number  output  8  target value driven to the comparator stage.
REQ-011 score  output  8  rounds won in the current game.
REQ-012 time_left  output  8  ticks remaining in the current round.
REQ-013 round_idx  output  8  rounds completed in the current game.
REQ-014 playing  output  1  high in GUARD and PLAY; game_over  output  1  high in OVER.
REQ-015 hit  output  1  one-cycle pulse on a won round; miss  output  1  one-cycle pulse on a timed-out round.

Function
REQ-016 SHALL implement states IDLE, LOAD, GUARD, PLAY, RESULT, OVER.
REQ-017 IDLE/OVER + start -> LOAD, clearing score and round_idx; start is ignored in all other states.
REQ-018 LOAD (1 cycle) SHALL copy the LFSR value to number, set time_left=ROUND_TICKS, then go to GUARD.
REQ-019 GUARD SHALL last exactly 2 cycles and ignore is_equal, masking the comparator's stale registered result; then go to PLAY.
REQ-020 In PLAY, tick SHALL decrement time_left by 1, and time_left SHALL never go below 0.
REQ-021 In PLAY, a qualified match SHALL assert hit for 1 cycle, increment score (saturating at 255), and go to RESULT.
REQ-022 In PLAY, tick with time_left==1 and no qualified match SHALL set time_left=0, assert miss for 1 cycle, and go to RESULT.
REQ-023 When a qualified match and a final tick occur in the same cycle, the match SHALL win: hit asserts, miss does not.
REQ-024 RESULT (1 cycle) SHALL increment round_idx, then go to OVER if round_idx+1==MAX_ROUNDS, else to LOAD.
REQ-025 The 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) SHALL advance every cycle in every state, so number is never 0.
REQ-026 number SHALL hold its value between LOAD events.
REQ-027 Latency SHALL be: is_equal high in PLAY -> hit on the next clock edge (without the macro).

Reset
REQ-028 rst SHALL immediately force: state=IDLE, number=0, score=0, time_left=0, round_idx=0, playing=0, game_over=0, hit=0, miss=0, LFSR=LFSR_SEED, hold counter=0.
REQ-029 rst asserted mid-game SHALL abandon the round with no hit or miss pulse.

Configuration
REQ-030 Macro HOLD_CONFIRM_EN defined: a match SHALL be qualified only after is_equal is high in PLAY for CONFIRM_CYCLES consecutive cycles; any low cycle clears the hold counter, and the counter clears on leaving PLAY.
REQ-031 Macro HOLD_CONFIRM_EN undefined: any single PLAY cycle with is_equal=1 SHALL be a qualified match, and no hold counter SHALL exist.

Structure
REQ-032 Shared package binary_game_pkg SHALL hold the state enum, LFSR tap constant, and the 8-bit value width constant.
REQ-033 The LFSR SHALL be sub-module lfsr8 (ports clk, rst, seed, q), instantiated once.

Verification
REQ-034 rst, start, is_equal=1 held throughout -> no hit during LOAD/GUARD; hit on the 1st PLAY cycle (macro off) or the 4th PLAY cycle (macro on); score=1.
REQ-035 ROUND_TICKS=3, is_equal=0, 3 ticks in PLAY -> time_left steps 3,2,1,0; one miss pulse; score stays 0.
REQ-036 Final tick and is_equal=1 in the same PLAY cycle -> hit=1, miss=0, score increments.
REQ-037 MAX_ROUNDS=2, win both rounds -> round_idx=2, game_over=1; then start -> score=0, round_idx=0, new LOAD.
REQ-038 Macro on, is_equal pattern 1,1,1,0,1,1,1,1 -> exactly one hit, after the 8th cycle.
REQ-039 rst pulsed mid-PLAY -> all outputs 0 at once, state IDLE, no pulses; LFSR restarts from 8'hA5.
